if1_pcgen: RTL and testbench
============================

IF1_PCGEN -- requirements
Module: if1_pcgen

Interface
REQ-001 Parameter FETCH_WIDTH, default 4: instructions per fetch group; power of two, 1..8.
REQ-002 Parameter RESET_PC, default 32'h1c00_0000: PC loaded on reset.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 bp_taken  input  1  branch predictor predicts taken for current group.
REQ-006 bp_target  input  32  predicted target, used when bp_taken=1.
REQ-007 EX_BR  input  1  execute-stage redirect (mispredict).
REQ-008 pc_BR  input  32  execute redirect target.
REQ-009 BR_predecoder  input  1  predecoder redirect.
REQ-010 PC_predecoder  input  32  predecoder redirect target.
REQ-011 stall_ICache  input  1  ICache busy; hold PC.
REQ-012 stall_full_instr  input  1  instruction buffer full; hold PC.
REQ-013 pc_IF1  output  32  current fetch PC.
REQ-014 is_valid  output  1  current group is a real fetch request.
REQ-015 valid_mask  output  FETCH_WIDTH  per-slot validity within the group.
REQ-016 fetch_adef  output  1  pc_IF1[1:0]!=0 (fetch address error).

Function
REQ-017 stall = stall_ICache | stall_full_instr.
REQ-018 Internal valid_r is 0 after reset, set to 1 on the first rising edge with rstn=1, then stays 1.
REQ-019 is_valid = valid_r & ~stall & ~BR_predecoder & ~EX_BR, combinational.
REQ-020 Next-PC priority per edge: EX_BR -> pc_BR; else BR_predecoder -> PC_predecoder; else stall -> hold; else bp_taken -> bp_target; else sequential.
REQ-021 Sequential PC = (pc_IF1 with bits [log2(FETCH_WIDTH)+1:0] cleared) + 4*FETCH_WIDTH, modulo 2^32 (wraps 0xFFFF_FFF0 -> 0 for width 4).
REQ-022 Slot offset = pc_IF1[log2(FETCH_WIDTH)+1:2] (0 when FETCH_WIDTH=1); valid_mask[i] = (i >= offset) & is_valid.
REQ-023 fetch_adef = valid_r & (pc_IF1[1:0]!=0); when asserted valid_mask has only bit [offset] set (if is_valid), so the exception rides slot offset.
REQ-024 Redirect targets are taken verbatim; no alignment applied to pc_IF1.
REQ-025 EX_BR and BR_predecoder simultaneous: EX_BR wins, predecoder target discarded.
REQ-026 Redirect during stall (macro absent): applied on the same edge; stall does not block redirects.

Reset
REQ-027 While rstn=0, immediately: pc_IF1=RESET_PC, valid_r=0, pending state cleared; is_valid=0, valid_mask=0, fetch_adef=0.
REQ-028 Reset asserted mid-stall or with a pending redirect discards all in-flight state; first post-reset fetch is RESET_PC.

Configuration
REQ-029 Macro IF1_REDIRECT_BUF_EN, when defined, adds a one-entry pending-redirect register (valid bit + 32-bit target).
REQ-030 With macro: a redirect arriving while stall_ICache=1 is latched (EX_BR overwrites any pending entry; BR_predecoder only if no EX_BR-sourced entry pending); pc_IF1 holds until stall_ICache drops.
REQ-031 With macro: on first edge with stall_ICache=0, pc_IF1 loads a live EX_BR target if present, else the pending target; pending clears; is_valid=0 while entry pending.
REQ-032 With macro: redirects during stall_full_instr only (stall_ICache=0) apply immediately per REQ-020.
REQ-033 Without macro: no pending register; behaviour per REQ-020/026.

Verification (FETCH_WIDTH=4, RESET_PC=1c000000)
REQ-034 Release rstn, no stall, bp_taken=0 -> cycle0 pc=1c000000 is_valid=0; next edge pc=1c000010, valid_mask=1111.
REQ-035 pc=1c000010, bp_taken=1, bp_target=1c000108 -> pc=1c000108, valid_mask=1100.
REQ-036 EX_BR=1 pc_BR=1c000200 with BR_predecoder=1 PC_predecoder=1c000300 -> pc=1c000200, is_valid=0 that cycle.
REQ-037 stall_ICache=1 for 3 cycles, BR_predecoder pulse cycle 1 target 1c000400 -> with macro pc held, is_valid=0, pc=1c000400 on edge after stall drops; without macro pc=1c000400 on edge after pulse.
REQ-038 pc_BR=1c000006 -> pc=1c000006, fetch_adef=1, valid_mask=0010.
REQ-039 rstn low asynchronously mid-stall with pending redirect -> pc=1c000000 immediately, is_valid=0, pending cleared.

Source files
------------

// File: rtl/if1_pcgen.sv
// IF1 fetch-PC generator: picks the next fetch-group PC from redirects, stalls,
// the branch predictor or sequential advance. IF1_REDIRECT_BUF_EN adds a pending-redirect entry.
module if1_pcgen #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h1c00_0000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   bp_taken,
  input  logic [31:0]            bp_target,
  input  logic                   EX_BR,
  input  logic [31:0]            pc_BR,
  input  logic                   BR_predecoder,
  input  logic [31:0]            PC_predecoder,
  input  logic                   stall_ICache,
  input  logic                   stall_full_instr,
  output logic [31:0]            pc_IF1,
  output logic                   is_valid,
  output logic [FETCH_WIDTH-1:0] valid_mask,
  output logic                   fetch_adef
);

  localparam int unsigned OFF_W       = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [31:0] GROUP_BYTES = 32'(4 * FETCH_WIDTH);
  localparam logic [31:0] ALIGN_MASK  = ~(GROUP_BYTES - 32'd1);

  logic [31:0]            pc_q;
  logic [31:0]            pc_d;
  logic                   valid_q;
  logic                   stall_s;
  logic                   pend_block_s;
  logic [31:0]            seq_pc_s;
  logic [31:0]            base_next_s;
  logic [OFF_W-1:0]       slot_off_s;
  logic [FETCH_WIDTH-1:0] mask_s;

  assign stall_s    = stall_ICache | stall_full_instr;
  assign seq_pc_s   = (pc_q & ALIGN_MASK) + GROUP_BYTES;
  assign slot_off_s = (FETCH_WIDTH > 1) ? OFF_W'(pc_q[31:2]) : '0;

  assign pc_IF1     = pc_q;
  assign fetch_adef = valid_q & (pc_q[1:0] != 2'b00);
  assign is_valid   = valid_q & ~stall_s & ~BR_predecoder & ~EX_BR & ~pend_block_s;
  assign valid_mask = mask_s;

  // Slot validity; a misaligned PC confines the group to its first slot so the exception rides it.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (fetch_adef) begin
        mask_s[i] = is_valid & (OFF_W'(i) == slot_off_s);
      end else begin
        mask_s[i] = is_valid & (OFF_W'(i) >= slot_off_s);
      end
    end
  end

  // Next PC ignoring execute redirects and any pending entry.
  always_comb begin
    base_next_s = seq_pc_s;
    if (BR_predecoder) begin
      base_next_s = PC_predecoder;
    end else if (stall_s) begin
      base_next_s = pc_q;
    end else if (bp_taken) begin
      base_next_s = bp_target;
    end else begin
      base_next_s = seq_pc_s;
    end
  end

`ifdef IF1_REDIRECT_BUF_EN
  logic        pend_vld_q;
  logic        pend_vld_d;
  logic        pend_ex_q;
  logic        pend_ex_d;
  logic [31:0] pend_tgt_q;
  logic [31:0] pend_tgt_d;

  assign pend_block_s = pend_vld_q;

  // While the ICache stalls, redirects are parked; an execute-sourced entry outranks the predecoder.
  always_comb begin
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_ex_d  = pend_ex_q;
    pend_tgt_d = pend_tgt_q;
    if (stall_ICache) begin
      if (EX_BR) begin
        pend_vld_d = 1'b1;
        pend_ex_d  = 1'b1;
        pend_tgt_d = pc_BR;
      end else if (BR_predecoder && !(pend_vld_q && pend_ex_q)) begin
        pend_vld_d = 1'b1;
        pend_ex_d  = 1'b0;
        pend_tgt_d = PC_predecoder;
      end else begin
        pend_vld_d = pend_vld_q;
      end
    end else begin
      pend_vld_d = 1'b0;
      pend_ex_d  = 1'b0;
      if (EX_BR) begin
        pc_d = pc_BR;
      end else if (pend_vld_q) begin
        pc_d = pend_tgt_q;
      end else begin
        pc_d = base_next_s;
      end
    end
  end

  // Pending-redirect entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_vld_q <= 1'b0;
      pend_ex_q  <= 1'b0;
      pend_tgt_q <= 32'h0000_0000;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_ex_q  <= pend_ex_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end
`else
  assign pend_block_s = 1'b0;

  // Execute redirect has top priority and is not blocked by stalls.
  always_comb begin
    pc_d = base_next_s;
    if (EX_BR) begin
      pc_d = pc_BR;
    end else begin
      pc_d = base_next_s;
    end
  end
`endif

  // Fetch PC and the first-cycle-after-reset qualifier.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if1_pcgen.sv
// Randomized self-checking bench for if1_pcgen against a behavioural next-PC model.
// Honours IF1_REDIRECT_BUF_EN when the design is built with it.
module tb_if1_pcgen;

  localparam int unsigned FW   = 4;
  localparam logic [31:0] RPC  = 32'h1c00_0000;
  localparam logic [31:0] STEP = 32'(4 * FW);
`ifdef IF1_REDIRECT_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          bp_taken = 1'b0;
  logic [31:0]   bp_target = 32'h0;
  logic          EX_BR = 1'b0;
  logic [31:0]   pc_BR = 32'h0;
  logic          BR_predecoder = 1'b0;
  logic [31:0]   PC_predecoder = 32'h0;
  logic          stall_ICache = 1'b0;
  logic          stall_full_instr = 1'b0;
  logic [31:0]   pc_IF1;
  logic          is_valid;
  logic [FW-1:0] valid_mask;
  logic          fetch_adef;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic [31:0] m_pt;
  bit          m_valid;
  bit          m_pv;
  bit          m_pex;

  if1_pcgen #(.FETCH_WIDTH(FW), .RESET_PC(RPC)) dut (
    .clk(clk), .rstn(rstn),
    .bp_taken(bp_taken), .bp_target(bp_target),
    .EX_BR(EX_BR), .pc_BR(pc_BR),
    .BR_predecoder(BR_predecoder), .PC_predecoder(PC_predecoder),
    .stall_ICache(stall_ICache), .stall_full_instr(stall_full_instr),
    .pc_IF1(pc_IF1), .is_valid(is_valid), .valid_mask(valid_mask), .fetch_adef(fetch_adef)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_valid = 1'b0; m_pv = 1'b0; m_pex = 1'b0; m_pt = 32'h0;
  endtask

  // Expected outputs from the current model state and live inputs.
  task automatic model_check();
    bit            stall;
    bit            adef;
    bit            isv;
    int unsigned   off;
    logic [FW-1:0] em;
    stall = stall_ICache | stall_full_instr;
    off   = (m_pc / 4) % FW;
    adef  = m_valid && ((m_pc % 4) != 0);
    isv   = m_valid && !stall && !BR_predecoder && !EX_BR && !(BUF && m_pv);
    em    = '0;
    for (int i = 0; i < FW; i++)
      em[i] = isv && (adef ? (i == off) : (i >= off));
    chk("pc", pc_IF1, m_pc);
    chk("is_valid", {31'd0, is_valid}, {31'd0, isv});
    chk("valid_mask", {28'd0, valid_mask}, {28'd0, em});
    chk("fetch_adef", {31'd0, fetch_adef}, {31'd0, adef});
  endtask

  // Model state after the coming rising edge.
  task automatic model_next();
    logic [31:0] seq;
    seq = (m_pc / STEP) * STEP + STEP;
    if (!rstn) begin
      model_reset();
    end else begin
      if (BUF && stall_ICache) begin
        if (EX_BR) begin
          m_pv = 1'b1; m_pex = 1'b1; m_pt = pc_BR;
        end else if (BR_predecoder && !(m_pv && m_pex)) begin
          m_pv = 1'b1; m_pex = 1'b0; m_pt = PC_predecoder;
        end
      end else begin
        if (EX_BR)                              m_pc = pc_BR;
        else if (BUF && m_pv)                   m_pc = m_pt;
        else if (BR_predecoder)                 m_pc = PC_predecoder;
        else if (stall_ICache | stall_full_instr) m_pc = m_pc;
        else if (bp_taken)                      m_pc = bp_target;
        else                                    m_pc = seq;
        m_pv = 1'b0; m_pex = 1'b0;
      end
      m_valid = 1'b1;
    end
  endtask

  task automatic step();
    #1;
    model_check();
    model_next();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bp_taken = 1'b0; EX_BR = 1'b0; BR_predecoder = 1'b0;
    stall_ICache = 1'b0; stall_full_instr = 1'b0;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(0, 7))
      0:       t = 32'hFFFF_FFE0 | (t & 32'h0000_001C);
      1:       t = t;
      default: t[1:0] = 2'b00;
    endcase
    return t;
  endfunction

  initial begin
    model_reset();
    clear_inputs();
    @(negedge clk);
    #1;
    chk("rst_pc", pc_IF1, RPC);
    chk("rst_is_valid", {31'd0, is_valid}, 32'd0);
    chk("rst_mask", {28'd0, valid_mask}, 32'd0);
    chk("rst_adef", {31'd0, fetch_adef}, 32'd0);
    step();

    rstn = 1'b1;
    #1;
    chk("first_pc", pc_IF1, 32'h1c00_0000);
    chk("first_is_valid", {31'd0, is_valid}, 32'd0);
    step();
    #1;
    chk("seq_pc", pc_IF1, 32'h1c00_0010);
    chk("seq_mask", {28'd0, valid_mask}, 32'hF);

    bp_taken = 1'b1; bp_target = 32'h1c00_0108;
    step();
    bp_taken = 1'b0;
    #1;
    chk("bp_pc", pc_IF1, 32'h1c00_0108);
    chk("bp_mask", {28'd0, valid_mask}, 32'hC);

    EX_BR = 1'b1; pc_BR = 32'h1c00_0200; BR_predecoder = 1'b1; PC_predecoder = 32'h1c00_0300;
    #1;
    chk("both_redirect_is_valid", {31'd0, is_valid}, 32'd0);
    step();
    clear_inputs();
    #1;
    chk("ex_wins_pc", pc_IF1, 32'h1c00_0200);

    stall_ICache = 1'b1;
    step();
    BR_predecoder = 1'b1; PC_predecoder = 32'h1c00_0400;
    step();
    BR_predecoder = 1'b0;
    #1;
`ifdef IF1_REDIRECT_BUF_EN
    chk("stall_pre_held", pc_IF1, 32'h1c00_0200);
`else
    chk("stall_pre_applied", pc_IF1, 32'h1c00_0400);
`endif
    step();
    stall_ICache = 1'b0;
    #1;
`ifdef IF1_REDIRECT_BUF_EN
    chk("pending_pc_held", pc_IF1, 32'h1c00_0200);
    chk("pending_is_valid", {31'd0, is_valid}, 32'd0);
`else
    chk("after_stall_pc", pc_IF1, 32'h1c00_0400);
`endif
    step();
    #1;
`ifdef IF1_REDIRECT_BUF_EN
    chk("pending_applied", pc_IF1, 32'h1c00_0400);
`else
    chk("after_stall_seq", pc_IF1, 32'h1c00_0410);
`endif

    EX_BR = 1'b1; pc_BR = 32'h1c00_0006;
    step();
    EX_BR = 1'b0;
    #1;
    chk("adef_pc", pc_IF1, 32'h1c00_0006);
    chk("adef_flag", {31'd0, fetch_adef}, 32'd1);
    chk("adef_mask", {28'd0, valid_mask}, 32'h2);
    step();
    #1;
    chk("adef_seq", pc_IF1, 32'h1c00_0010);

    EX_BR = 1'b1; pc_BR = 32'hFFFF_FFF4;
    step();
    EX_BR = 1'b0;
    step();
    #1;
    chk("wrap_pc", pc_IF1, 32'h0000_0000);

    stall_ICache = 1'b1;
    step();
    BR_predecoder = 1'b1; PC_predecoder = 32'h1c00_0500;
    step();
    BR_predecoder = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    chk("async_rst_pc", pc_IF1, RPC);
    chk("async_rst_is_valid", {31'd0, is_valid}, 32'd0);
    chk("async_rst_mask", {28'd0, valid_mask}, 32'd0);
    model_reset();
    step();
    rstn = 1'b1; stall_ICache = 1'b0;
    #1;
    chk("post_rst_pc", pc_IF1, RPC);
    step();
    #1;
    chk("post_rst_seq", pc_IF1, 32'h1c00_0010);

    for (int i = 0; i < 3000; i++) begin
      EX_BR            = ($urandom_range(0, 9) == 0);
      BR_predecoder    = ($urandom_range(0, 7) == 0);
      stall_ICache     = ($urandom_range(0, 3) == 0);
      stall_full_instr = ($urandom_range(0, 5) == 0);
      bp_taken         = ($urandom_range(0, 2) == 0);
      pc_BR            = rand_target();
      PC_predecoder    = rand_target();
      bp_target        = rand_target();
      if ((i % 400) == 199) begin
        #2;
        rstn = 1'b0;
        model_reset();
        step();
        rstn = 1'b1;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
